reg_dump_scanner: RTL and testbench
===================================

REG_DUMP_SCANNER -- requirements
Module: reg_dump_scanner

Interface
REQ-001 SHALL use one clock and an asynchronous, active-low reset.
REQ-002 iCLK  in  1  system clock; all state updates on the rising edge.
REQ-003 iRST_n  in  1  asynchronous reset, active-low.
REQ-004 iStart  in  1  start-of-dump pulse; sampled only in IDLE.
REQ-005 iAbort  in  1  terminate dump; returns to IDLE.
REQ-006 iFirstReg, iLastReg  in  5 each  inclusive dump range; wraps 31->0 when iFirstReg > iLastReg.
REQ-007 iRegData  in  64  combinational read data from the register file monitoring port.
REQ-008 iReady  in  1  downstream sink accepts oData.
REQ-009 oRegSelect  out  5  register index driven to the register file monitoring select.
REQ-010 oData  out  64  captured register value; oIndex  out  5  its register number.
REQ-011 oValid  out  1  oData/oIndex valid; oBusy  out  1  dump in progress; oDone  out  1  one-cycle end-of-dump pulse.

Function
REQ-012 SHALL implement the FSM IDLE, SELECT, SEND, DONE.
REQ-013 IDLE: iStart=1 SHALL latch ptr<=iFirstReg and last<=iLastReg, then go to SELECT; range inputs are ignored after the latch.
REQ-014 oRegSelect SHALL equal ptr in every state.
REQ-015 SELECT lasts one cycle; on exit SHALL capture oData<=iRegData, oIndex<=ptr, set oValid=1, and go to SEND.
REQ-016 SEND: oValid, oData and oIndex SHALL hold stable until oValid&&iReady.
REQ-017 On handshake with ptr==last SHALL go to DONE; otherwise ptr<=ptr+1 (5-bit, 31 wraps to 0) and go to SELECT.
REQ-018 Handshake SHALL clear oValid in the same edge; throughput is one word per 2 cycles with iReady held high.
REQ-019 DONE SHALL assert oDone for exactly one cycle, then go to IDLE.
REQ-020 oBusy SHALL be 1 in SELECT and SEND, and 0 in IDLE and DONE.
REQ-021 iFirstReg==iLastReg SHALL emit exactly one word.
REQ-022 Word count SHALL be ((iLastReg-iFirstReg) mod 32)+1; 0..31 gives 32 words.
REQ-023 iAbort in SELECT or SEND SHALL go to IDLE next edge with oValid=0 and no oDone; iAbort has priority over handshake.
REQ-024 iStart while not IDLE SHALL be ignored.
REQ-025 Latency: iStart at edge N gives oValid=1 after edge N+2.

Reset
REQ-026 iRST_n=0 SHALL immediately force IDLE, ptr=0, last=0, oRegSelect=0, oData=0, oIndex=0, oValid=0, oBusy=0, oDone=0, including mid-dump.
REQ-027 After reset release, no output SHALL change until iStart.

Configuration
REQ-028 Macro DUMP_SKIP_ZERO_EN: when defined, SELECT with iRegData==0 SHALL emit no word. In that case, if ptr!=last it SHALL do ptr<=ptr+1 and stay in SELECT; otherwise it SHALL go to DONE.
REQ-029 Without DUMP_SKIP_ZERO_EN, every register in range SHALL be emitted regardless of value.

Verification
REQ-030 Range 0..3, regs=0,0,0,0x10 (slot 3), iReady=1, macro off -> 4 words, oIndex 0,1,2,3, last oData=0x10, oDone 1 cycle after 4th handshake.
REQ-031 Same stimulus, DUMP_SKIP_ZERO_EN on -> exactly 1 word (oIndex=3, oData=0x10), then oDone.
REQ-032 Range 30..1, iReady=1 -> oIndex sequence 30,31,0,1, then oDone.
REQ-033 Range 5..5, iReady low 10 cycles -> oValid held, oData/oIndex stable; iReady=1 -> handshake, oDone next cycle.
REQ-034 Range 0..31, iAbort asserted during 3rd SEND -> oValid=0, oBusy=0 next cycle, no oDone; new iStart restarts at iFirstReg.
REQ-035 iRST_n=0 mid-SEND -> all outputs zero asynchronously; iStart pulse during reset ignored.

Source files
------------

// File: rtl/reg_dump_scanner.sv
// reg_dump_scanner: walks an inclusive, wrapping register range and streams each value out with a valid/ready handshake
//   Ports:
//     iCLK, iRST_n          clock, asynchronous active-low reset
//     iStart, iAbort        start-of-dump pulse (honoured only when idle), dump abort
//     iFirstReg, iLastReg   inclusive index range; iFirstReg > iLastReg wraps through 31 -> 0
//     iRegData              combinational read data for the index on oRegSelect
//     iReady                downstream accepts oData/oIndex
//     oRegSelect            register index presented to the register file
//     oData, oIndex         captured value and its register number
//     oValid, oBusy, oDone  word valid, dump in progress, one-cycle end-of-dump pulse
//   Build option: define DUMP_SKIP_ZERO_EN to drop zero-valued registers from the dump.
module reg_dump_scanner (
    input  logic        iCLK,
    input  logic        iRST_n,
    input  logic        iStart,
    input  logic        iAbort,
    input  logic [4:0]  iFirstReg,
    input  logic [4:0]  iLastReg,
    input  logic [63:0] iRegData,
    input  logic        iReady,
    output logic [4:0]  oRegSelect,
    output logic [63:0] oData,
    output logic [4:0]  oIndex,
    output logic        oValid,
    output logic        oBusy,
    output logic        oDone
);
    typedef enum logic [1:0] {IDLE, SELECT, SEND, DONE} state_t;
    state_t     state;
    logic [4:0] ptr;
    logic [4:0] last;
    assign oRegSelect = ptr;
    // oBusy and oDone are registered alongside each state transition so they track the state with no decode glitches.
    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            state  <= IDLE;
            ptr    <= '0;
            last   <= '0;
            oData  <= '0;
            oIndex <= '0;
            oValid <= 1'b0;
            oBusy  <= 1'b0;
            oDone  <= 1'b0;
        end else begin
            oDone <= 1'b0;
            case (state)
                IDLE: if (iStart) begin
                    ptr   <= iFirstReg;
                    last  <= iLastReg;
                    oBusy <= 1'b1;
                    state <= SELECT;
                end
                SELECT: if (iAbort) begin
                    oBusy <= 1'b0;
                    state <= IDLE;
                end
`ifdef DUMP_SKIP_ZERO_EN
                else if (iRegData == '0) begin
                    if (ptr != last) ptr <= ptr + 5'd1;
                    else begin
                        oBusy <= 1'b0;
                        oDone <= 1'b1;
                        state <= DONE;
                    end
                end
`endif
                else begin
                    oData  <= iRegData;
                    oIndex <= ptr;
                    oValid <= 1'b1;
                    state  <= SEND;
                end
                // Abort wins over a simultaneous handshake: the word is dropped, not delivered.
                SEND: if (iAbort) begin
                    oValid <= 1'b0;
                    oBusy  <= 1'b0;
                    state  <= IDLE;
                end else if (iReady) begin
                    oValid <= 1'b0;
                    if (ptr == last) begin
                        oBusy <= 1'b0;
                        oDone <= 1'b1;
                        state <= DONE;
                    end else begin
                        ptr   <= ptr + 5'd1;
                        state <= SELECT;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_reg_dump_scanner.sv
// tb_reg_dump_scanner: table-driven dump runs checked against a scoreboard of expected words, plus abort and reset sequences
module tb_reg_dump_scanner;
    logic        iCLK = 1'b0;
    logic        iRST_n = 1'b0;
    logic        iStart = 1'b0;
    logic        iAbort = 1'b0;
    logic        iReady = 1'b0;
    logic [4:0]  iFirstReg = '0;
    logic [4:0]  iLastReg = '0;
    logic [63:0] iRegData;
    logic [4:0]  oRegSelect;
    logic [63:0] oData;
    logic [4:0]  oIndex;
    logic        oValid;
    logic        oBusy;
    logic        oDone;
    typedef struct {
        logic [4:0]  idx;
        logic [63:0] data;
    } exp_t;
    typedef struct {
        logic [4:0] first;
        logic [4:0] last;
        int         rmode;
        int         n;
    } vec_t;
    logic [63:0] regs [32];
    exp_t        exp_q [$];
    exp_t        e;
    vec_t        vecs [7];
    int          n_cmp = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          words = 0;
    int          dones = 0;
    int          last_hs = 0;
    int          run_cyc = 0;
    bit          ready_always = 1'b0;
    bit          hold = 1'b0;
    bit          prev_abort = 1'b0;
    logic [63:0] prev_d;
    logic [4:0]  prev_i;

    reg_dump_scanner dut (
        .iCLK(iCLK), .iRST_n(iRST_n), .iStart(iStart), .iAbort(iAbort),
        .iFirstReg(iFirstReg), .iLastReg(iLastReg), .iRegData(iRegData), .iReady(iReady),
        .oRegSelect(oRegSelect), .oData(oData), .oIndex(oIndex),
        .oValid(oValid), .oBusy(oBusy), .oDone(oDone)
    );

    assign iRegData = regs[oRegSelect];
    always #5 iCLK = ~iCLK;
    always @(posedge iCLK) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [79:0] act, input logic [79:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic chk_zero(input string nm);
        check(nm, {oRegSelect, oData, oIndex, oValid, oBusy, oDone}, '0);
    endtask

    // Scoreboard side: every accepted word is popped and compared; hold/throughput/done timing checked here too.
    always @(negedge iCLK) begin
        if (!iRST_n) hold = 1'b0;
        else begin
            if (hold && !prev_abort) check("hold_stable", {oValid, oIndex, oData}, {1'b1, prev_i, prev_d});
            if (oValid) check("regsel_idx", oRegSelect, oIndex);
            if (oValid && iReady && !iAbort) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL extra_word: got idx %0d data %0h expected no word", oIndex, oData);
                end else begin
                    e = exp_q.pop_front();
                    check("word_idx", oIndex, e.idx);
                    check("word_data", oData, e.data);
                end
                if (ready_always && last_hs >= run_cyc) check("throughput", cyc - last_hs, 2);
                last_hs = cyc;
                words++;
            end
            if (oDone) begin
                dones++;
                check("done_busy", oBusy, 0);
                if (ready_always) check("done_latency", cyc - last_hs, 1);
            end
            hold = oValid && !iReady;
            prev_abort = iAbort;
            prev_d = oData;
            prev_i = oIndex;
        end
    end

    task automatic push_range(input logic [4:0] first, input logic [4:0] last);
        logic [4:0] p;
        p = first;
        for (int k = 0; k < 32; k++) begin
`ifdef DUMP_SKIP_ZERO_EN
            if (regs[p] != 0) exp_q.push_back('{p, regs[p]});
`else
            exp_q.push_back('{p, regs[p]});
`endif
            if (p == last) break;
            p++;
        end
    endtask

    // rmode: 0 ready always high, 1 random ready plus a stray start pulse, 2 ready low for 10 cycles then high
    task automatic run_dump(input logic [4:0] first, input logic [4:0] last, input int rmode, input int n, input bit chk_lat);
        int w0;
        int d0;
        push_range(first, last);
        w0 = words;
        d0 = dones;
        ready_always = (rmode == 0);
        iReady = (rmode == 0);
        @(posedge iCLK); #1;
        iStart = 1'b1;
        iFirstReg = first;
        iLastReg = last;
        run_cyc = cyc;
        @(posedge iCLK); #1;
        iStart = 1'b0;
        iFirstReg = ~first;
        iLastReg = ~last;
        @(negedge iCLK);
        check("lat_busy", {oBusy, oValid}, 2'b10);
        @(negedge iCLK);
        if (chk_lat) check("lat_valid", oValid, 1);
        for (int c = 0; c < 800 && dones == d0; c++) begin
            @(posedge iCLK); #1;
            iReady = rmode == 1 ? ($urandom_range(0, 1) == 1) : rmode == 2 ? (c >= 10) : 1'b1;
            iStart = (rmode == 1 && c == 2);
            if (iStart) begin
                iFirstReg = 5'd17;
                iLastReg = 5'd17;
            end
        end
        iStart = 1'b0;
        check("done_seen", dones - d0, 1);
        check("word_count", words - w0, n);
        check("queue_empty", exp_q.size(), 0);
        repeat (3) @(negedge iCLK);
        #1;
        check("done_once", dones - d0, 1);
        check("idle_busy", {oBusy, oValid}, 0);
    endtask

    initial begin
        int w0;
        int d0;
        for (int i = 0; i < 32; i++) regs[i] = {$urandom, $urandom} | 64'h1;
        vecs[0] = '{5'd0, 5'd3, 0, 4};
        vecs[1] = '{5'd30, 5'd1, 0, 4};
        vecs[2] = '{5'd5, 5'd5, 2, 1};
        vecs[3] = '{5'd10, 5'd9, 0, 32};
        vecs[4] = '{5'd12, 5'd20, 1, 9};
        vecs[5] = '{5'd31, 5'd0, 1, 2};
        vecs[6] = '{5'd0, 5'd31, 1, 32};
        iStart = 1'b1;
        repeat (3) @(negedge iCLK);
        chk_zero("reset_state");
        @(posedge iCLK); #1;
        iRST_n = 1'b1;
        iStart = 1'b0;
        repeat (3) @(negedge iCLK);
        chk_zero("post_reset_quiet");
        for (int v = 0; v < 7; v++) run_dump(vecs[v].first, vecs[v].last, vecs[v].rmode, vecs[v].n, 1'b1);
        regs[0] = 64'h0;
        regs[1] = 64'h0;
        regs[2] = 64'h0;
        regs[3] = 64'h10;
`ifdef DUMP_SKIP_ZERO_EN
        run_dump(5'd0, 5'd3, 0, 1, 1'b0);
`else
        run_dump(5'd0, 5'd3, 0, 4, 1'b1);
`endif
        for (int i = 0; i < 3; i++) regs[i] = {$urandom, $urandom} | 64'h1;
        push_range(5'd0, 5'd1);
        w0 = words;
        d0 = dones;
        ready_always = 1'b0;
        iReady = 1'b1;
        @(posedge iCLK); #1;
        iStart = 1'b1;
        iFirstReg = 5'd0;
        iLastReg = 5'd31;
        @(posedge iCLK); #1;
        iStart = 1'b0;
        for (int c = 0; c < 50 && words - w0 < 2; c++) begin
            @(negedge iCLK); #1;
        end
        check("abort_reach", words - w0, 2);
        @(posedge iCLK); #1;
        @(posedge iCLK); #1;
        iAbort = 1'b1;
        @(negedge iCLK);
        check("abort_in_send", {oValid, oIndex}, {1'b1, 5'd2});
        @(posedge iCLK); #1;
        iAbort = 1'b0;
        @(negedge iCLK);
        check("abort_idle", {oValid, oBusy, oDone}, 0);
        repeat (4) @(negedge iCLK);
        #1;
        check("abort_no_done", dones - d0, 0);
        check("abort_words", words - w0, 2);
        check("abort_queue", exp_q.size(), 0);
        run_dump(5'd7, 5'd8, 0, 2, 1'b1);
        iReady = 1'b0;
        ready_always = 1'b0;
        @(posedge iCLK); #1;
        iStart = 1'b1;
        iFirstReg = 5'd4;
        iLastReg = 5'd9;
        @(posedge iCLK); #1;
        iStart = 1'b0;
        @(negedge iCLK);
        @(negedge iCLK);
        check("rst_pre_send", {oValid, oIndex}, {1'b1, 5'd4});
        #2;
        iRST_n = 1'b0;
        iStart = 1'b1;
        #1;
        chk_zero("rst_async");
        @(posedge iCLK); #1;
        @(posedge iCLK); #1;
        chk_zero("rst_hold");
        iRST_n = 1'b1;
        iStart = 1'b0;
        repeat (3) @(negedge iCLK);
        chk_zero("rst_release_quiet");
        run_dump(5'd3, 5'd6, 0, 4, 1'b1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
